// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - range-checks a signed value and packs it into the 27-bit immediate field
// Two-stage valid/ready pipeline: S1 holds the raw value, S2 holds the encoded field.
module imm_encoder #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       value,
  input  logic [1:0]        imm_src,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [26:0]       imm_field,
  output logic              overflow,
  output logic [ADDR_W-1:0] out_addr,
  output logic [CNT_W-1:0]  accepted_cnt,
  output logic [CNT_W-1:0]  error_cnt,
  output logic              err_sticky
);

  logic              s1_full_q, s1_full_d;
  logic [31:0]       s1_value_q, s1_value_d;
  logic [1:0]        s1_src_q, s1_src_d;

  logic              out_valid_q, out_valid_d;
  logic [26:0]       field_q, field_d;
  logic              ovf_q, ovf_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;

  logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              sticky_q, sticky_d;

  logic              s2_load;
  logic              s1_adv;
  logic              in_fire;
  logic              out_fire;
  logic [26:0]       enc_field;
  logic              enc_ovf;

  always_comb begin
    s2_load  = !out_valid_q || out_ready;
    s1_adv   = s1_full_q && s2_load;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid_q && out_ready;
  end

  assign in_ready = !s1_full_q || s1_adv;

  // A value fits in w bits when every bit from w-1 upward equals the sign bit.
  always_comb begin
    enc_field = '0;
    enc_ovf   = 1'b0;
    case (s1_src_q)
      2'b00: begin
        enc_field[11:0] = s1_value_q[11:0];
        enc_ovf = !((&s1_value_q[31:11]) || !(|s1_value_q[31:11]));
      end
      2'b01: begin
        enc_field[15:0] = s1_value_q[15:0];
        enc_ovf = !((&s1_value_q[31:15]) || !(|s1_value_q[31:15]));
      end
      2'b10: begin
        enc_field[23:0] = s1_value_q[23:0];
        enc_ovf = !((&s1_value_q[31:23]) || !(|s1_value_q[31:23]));
      end
      default: begin
        enc_field = s1_value_q[26:0];
        enc_ovf = !((&s1_value_q[31:26]) || !(|s1_value_q[31:26]));
      end
    endcase
  end

  always_comb begin
    s1_full_d   = s1_full_q;
    s1_value_d  = s1_value_q;
    s1_src_d    = s1_src_q;
    out_valid_d = out_valid_q;
    field_d     = field_q;
    ovf_d       = ovf_q;
    addr_d      = addr_q;
    addr_cnt_d  = addr_cnt_q;
    acc_cnt_d   = acc_cnt_q;
    err_cnt_d   = err_cnt_q;
    sticky_d    = sticky_q;

    if (s1_adv) begin
      s1_full_d = 1'b0;
    end
    if (in_fire) begin
      s1_full_d  = 1'b1;
      s1_value_d = value;
      s1_src_d   = imm_src;
    end

    // S2 keeps its last payload when it drains empty; only out_valid drops.
    if (s2_load) begin
      out_valid_d = s1_full_q;
      if (s1_full_q) begin
        field_d    = enc_field;
        ovf_d      = enc_ovf;
        addr_d     = addr_cnt_q;
        addr_cnt_d = addr_cnt_q + ADDR_W'(1);
      end
    end

    if (out_fire) begin
      if (acc_cnt_q != '1) begin
        acc_cnt_d = acc_cnt_q + CNT_W'(1);
      end
      if (ovf_q) begin
        sticky_d = 1'b1;
        if (err_cnt_q != '1) begin
          err_cnt_d = err_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_full_q   <= 1'b0;
      s1_value_q  <= '0;
      s1_src_q    <= '0;
      out_valid_q <= 1'b0;
      field_q     <= '0;
      ovf_q       <= 1'b0;
      addr_q      <= '0;
      addr_cnt_q  <= '0;
      acc_cnt_q   <= '0;
      err_cnt_q   <= '0;
      sticky_q    <= 1'b0;
    end else begin
      s1_full_q   <= s1_full_d;
      s1_value_q  <= s1_value_d;
      s1_src_q    <= s1_src_d;
      out_valid_q <= out_valid_d;
      field_q     <= field_d;
      ovf_q       <= ovf_d;
      addr_q      <= addr_d;
      addr_cnt_q  <= addr_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      err_cnt_q   <= err_cnt_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign imm_field    = field_q;
  assign overflow     = ovf_q;
  assign out_addr     = addr_q;
  assign accepted_cnt = acc_cnt_q;
  assign error_cnt    = err_cnt_q;
  assign err_sticky   = sticky_q;

endmodule
